wb_queue: RTL and testbench

Writeback queue that sits between the pipeline's writeback stage and the register file write port. It accepts register write requests through a valid/ready handshake and buffers them in order. It drains at most one request per cycle onto the register file's `reg_write`/`write_reg`/`write_data` port. It also forwards pending values to the read side so that reads issued before a write commits still see the newest value.

---
 rtl/wb_queue_if.sv | 27 ++
 rtl/wb_queue.sv | 138 +++++++++++++
 tb/tb_wb_queue.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_queue_if.sv
// Write-request channel into the writeback queue: one register write per
// valid/ready handshake.
interface wb_queue_if #(
   parameter int REG_W  = 5,
   parameter int DATA_W = 32
);
   logic              in_valid;
   logic              in_ready;
   logic [REG_W-1:0]  in_reg;
   logic [DATA_W-1:0] in_data;

   // Writeback stage side: drives requests, observes back-pressure.
   modport master (
      output in_valid,
      output in_reg,
      output in_data,
      input  in_ready
   );

   // Queue side: receives requests, drives back-pressure.
   modport slave (
      input  in_valid,
      input  in_reg,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue between the pipeline writeback stage and the register file
// write port. It buffers register writes in FIFO order, drains one per cycle
// into a registered write port, and forwards the newest pending value for a
// register to the read side.
module wb_queue #(
   parameter  int DEPTH  = 4,
   parameter  int DATA_W = 32,
   parameter  int REG_W  = 5,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset_n,
   wb_queue_if.slave         req,
   input  logic              hold,
   output logic              reg_write,
   output logic [REG_W-1:0]  write_reg,
   output logic [DATA_W-1:0] write_data,
   input  logic [REG_W-1:0]  fwd_reg1,
   input  logic [REG_W-1:0]  fwd_reg2,
   output logic              fwd_hit1,
   output logic              fwd_hit2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
   output logic [CNT_W-1:0]  count,
   output logic              drop
);

   typedef struct packed {
      logic [REG_W-1:0]  rg;
      logic [DATA_W-1:0] data;
   } entry_t;

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] data;
   } fwd_t;

   entry_t            mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              accept;
   logic              push;
   logic              pop;
   fwd_t              fwd1;
   fwd_t              fwd2;

   // Only registers 16..23 are backed by this queue.
   function automatic logic in_window(input logic [REG_W-1:0] r);
      return (r >= REG_W'(16)) && (r <= REG_W'(23));
   endfunction

   // Newest pending value for register r: the output stage is the oldest
   // candidate, then queue entries from head to tail, so a later match
   // overrides an earlier one and the youngest entry wins.
   function automatic fwd_t lookup(input logic [REG_W-1:0] r);
      fwd_t             res;
      logic [PTR_W-1:0] idx;
      // NOTE: every combinational result gets a default before any
      // conditional assignment, so no path leaves it unassigned (no latch).
      res = '0;
      idx = '0;
      if (in_window(r)) begin
         if (reg_write && (write_reg == r)) begin
            res.hit  = 1'b1;
            res.data = write_data;
         end
         for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (mem[idx].rg == r)) begin
               res.hit  = 1'b1;
               res.data = mem[idx].data;
            end
         end
      end
      return res;
   endfunction

   // Back-pressure depends only on current occupancy, never on a same-edge pop.
   assign req.in_ready = (count < CNT_W'(DEPTH));
   assign accept       = req.in_valid & req.in_ready;
   assign push         = accept & in_window(req.in_reg);
   assign pop          = (count != '0) & ~hold;

   // Pointers, occupancy, registered write port and drop pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         reg_write  <= 1'b0;
         write_reg  <= '0;
         write_data <= '0;
         drop       <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of statement order.
         drop <= accept & ~in_window(req.in_reg);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr     <= rd_ptr + PTR_W'(1);
            reg_write  <= 1'b1;
            write_reg  <= mem[rd_ptr].rg;
            write_data <= mem[rd_ptr].data;
         end else begin
            reg_write  <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage; written only on an accepted in-window request.
   // NOTE: the storage array has no reset; occupancy is tracked by count and
   // the pointers, so stale contents are never observed.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= '{rg: req.in_reg, data: req.in_data};
      end
   end

   // Combinational forwarding for both read ports.
   always_comb begin
      fwd1 = lookup(fwd_reg1);
      fwd2 = lookup(fwd_reg2);
   end

   assign fwd_hit1  = fwd1.hit;
   assign fwd_data1 = fwd1.data;
   assign fwd_hit2  = fwd2.hit;
   assign fwd_data2 = fwd2.data;

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: stimulus pushes expected register-file writes
// into a queue, a negedge monitor pops and compares whenever reg_write is high.
module tb_wb_queue;

   localparam int DEPTH  = 4;
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clock;
   logic              reset_n;
   logic              hold;
   logic              reg_write;
   logic [REG_W-1:0]  write_reg;
   logic [DATA_W-1:0] write_data;
   logic [REG_W-1:0]  fwd_reg1;
   logic [REG_W-1:0]  fwd_reg2;
   logic              fwd_hit1;
   logic              fwd_hit2;
   logic [DATA_W-1:0] fwd_data1;
   logic [DATA_W-1:0] fwd_data2;
   logic [CNT_W-1:0]  count;
   logic              drop;

   int tests = 0;
   int fails = 0;

   logic [REG_W+DATA_W-1:0] exp_q[$];

   wb_queue_if #(.REG_W(REG_W), .DATA_W(DATA_W)) bus ();

   wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (bus.slave),
      .hold       (hold),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .fwd_reg1   (fwd_reg1),
      .fwd_reg2   (fwd_reg2),
      .fwd_hit1   (fwd_hit1),
      .fwd_hit2   (fwd_hit2),
      .fwd_data1  (fwd_data1),
      .fwd_data2  (fwd_data2),
      .count      (count),
      .drop       (drop)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every register-file write must match the oldest expected one.
   always @(negedge clock) begin
      logic [REG_W+DATA_W-1:0] e;
      if (reset_n && reg_write) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got reg %0d data %h, none expected (t=%0t)",
                     write_reg, write_data, $time);
         end else begin
            e = exp_q.pop_front();
            check("wr_reg", 64'(write_reg), 64'(e[REG_W+DATA_W-1:DATA_W]));
            check("wr_data", 64'(write_data), 64'(e[DATA_W-1:0]));
         end
      end
   end

   // Issue one request; returns 1 time unit after the accepting edge.
   task automatic push(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
      bus.in_valid = 1'b1;
      bus.in_reg   = r;
      bus.in_data  = d;
      for (int t = 0; ; t++) begin
         if (t >= 50) begin
            check("push_timeout", 64'(0), 64'(1));
            break;
         end
         if (bus.in_ready) begin
            @(posedge clock);
            #1;
            if (r >= 16 && r <= 23) exp_q.push_back({r, d});
            break;
         end
         @(posedge clock);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   // Wait until the queue and output stage are empty, bounded.
   task automatic wait_idle();
      for (int t = 0; ; t++) begin
         if (count == 0 && !reg_write) break;
         if (t >= 40) begin
            check("drain_timeout", 64'(0), 64'(1));
            break;
         end
         @(posedge clock);
         #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n      = 1'b0;
      hold         = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_reg   = '0;
      bus.in_data  = '0;
      fwd_reg1     = '0;
      fwd_reg2     = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_count", 64'(count), 64'(0));
      check("rst_reg_write", 64'(reg_write), 64'(0));
      check("rst_write_reg", 64'(write_reg), 64'(0));
      check("rst_write_data", 64'(write_data), 64'(0));
      check("rst_drop", 64'(drop), 64'(0));
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'(1));

      // Single write, minimum latency.
      push(5'd17, 32'hA5A5_0001);
      check("t1_count_after_push", 64'(count), 64'(1));
      check("t1_no_write_yet", 64'(reg_write), 64'(0));
      @(posedge clock);
      #1;
      check("t1_reg_write", 64'(reg_write), 64'(1));
      check("t1_count_after_pop", 64'(count), 64'(0));
      @(posedge clock);
      #1;
      check("t1_reg_write_one_cycle", 64'(reg_write), 64'(0));

      // Fill under hold, stall a fifth request, then drain back-to-back.
      hold = 1'b1;
      for (int i = 0; i < 4; i++) push(REG_W'(16 + i), 32'h0000_0100 + 32'(i));
      check("t2_count_full", 64'(count), 64'(4));
      check("t2_in_ready_full", 64'(bus.in_ready), 64'(0));
      bus.in_valid = 1'b1;
      bus.in_reg   = 5'd20;
      bus.in_data  = 32'hDEAD_BEEF;
      repeat (2) @(posedge clock);
      #1;
      check("t2_stall_count", 64'(count), 64'(4));
      check("t2_stall_in_ready", 64'(bus.in_ready), 64'(0));
      bus.in_valid = 1'b0;
      hold = 1'b0;
      @(posedge clock);
      #1;
      check("t2_first_pop_count", 64'(count), 64'(3));
      check("t2_in_ready_back", 64'(bus.in_ready), 64'(1));
      check("t2_first_reg", 64'(write_reg), 64'(16));
      for (int i = 1; i < 4; i++) begin
         @(posedge clock);
         #1;
         check("t2_continuous_write", 64'(reg_write), 64'(1));
         check("t2_order", 64'(write_reg), 64'(16 + i));
      end
      @(posedge clock);
      #1;
      check("t2_drained", 64'(reg_write), 64'(0));

      // Forwarding: youngest wins, output stage still visible, misses read 0.
      hold     = 1'b1;
      fwd_reg1 = 5'd20;
      fwd_reg2 = 5'd21;
      push(5'd20, 32'd1);
      check("t3_fwd_first", 64'(fwd_data1), 64'(1));
      push(5'd20, 32'd2);
      check("t3_hit1", 64'(fwd_hit1), 64'(1));
      check("t3_data1_youngest", 64'(fwd_data1), 64'(2));
      check("t3_hit2_miss", 64'(fwd_hit2), 64'(0));
      check("t3_data2_zero", 64'(fwd_data2), 64'(0));
      fwd_reg2 = 5'd7;
      #1;
      check("t3_out_of_window", 64'(fwd_hit2), 64'(0));
      hold = 1'b0;
      @(posedge clock);
      #1;
      check("t3_queue_over_output", 64'(fwd_data1), 64'(2));
      @(posedge clock);
      #1;
      check("t3_output_stage_hit", 64'(fwd_hit1), 64'(1));
      check("t3_output_stage_data", 64'(fwd_data1), 64'(2));
      @(posedge clock);
      #1;
      check("t3_after_commit_hit", 64'(fwd_hit1), 64'(0));
      check("t3_after_commit_data", 64'(fwd_data1), 64'(0));

      // Out-of-window request is consumed and dropped.
      push(5'd5, 32'h0000_1234);
      check("t4_drop_pulse", 64'(drop), 64'(1));
      check("t4_count", 64'(count), 64'(0));
      @(posedge clock);
      #1;
      check("t4_drop_single", 64'(drop), 64'(0));
      check("t4_no_write", 64'(reg_write), 64'(0));

      // Simultaneous push and pop, then pointer wrap over 10 writes.
      hold = 1'b1;
      push(5'd16, 32'hE000_0001);
      push(5'd17, 32'hE000_0002);
      check("t5_count_two", 64'(count), 64'(2));
      hold = 1'b0;
      push(5'd18, 32'hE000_0003);
      check("t5_push_pop_count", 64'(count), 64'(2));
      for (int i = 0; i < 10; i++) push(REG_W'(16 + (i % 8)), 32'hC000_0000 + 32'(i));
      wait_idle();

      // Asynchronous reset mid-drain.
      hold = 1'b1;
      push(5'd21, 32'hF000_0000);
      push(5'd22, 32'hF000_0001);
      push(5'd23, 32'hF000_0002);
      push(5'd16, 32'hF000_0003);
      hold = 1'b0;
      @(posedge clock);
      #1;
      check("t6_pre_reset_write", 64'(reg_write), 64'(1));
      check("t6_pre_reset_count", 64'(count), 64'(3));
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check("t6_reset_reg_write", 64'(reg_write), 64'(0));
      check("t6_reset_count", 64'(count), 64'(0));
      check("t6_reset_write_data", 64'(write_data), 64'(0));
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      check("t6_no_writes_after", 64'(reg_write), 64'(0));
      check("t6_count_after", 64'(count), 64'(0));
      check("t6_in_ready_after", 64'(bus.in_ready), 64'(1));

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
